// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared FSM encoding, L/R polarity constants and default sizes.
// Rev 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_L = 3'd1,
    ST_GET_R = 3'd2,
    ST_PUT_L = 3'd3,
    ST_PUT_R = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  localparam logic WS_LEFT     = 1'b0;
  localparam logic TLAST_RIGHT = 1'b1;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_SCK_DIV    = 8;
  localparam int DEF_FRAME_BITS = 32;
  localparam int DEF_CNT_W      = 8;

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// i2s_clk_gen : sck/ws generation from the AXI clock plus frame/half-frame pulses.
// Rev 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SCK_DIV    = DEF_SCK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic ws,
  output logic frame_start,
  output logic half_frame
);

  localparam int DIV_W = $clog2(SCK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] r_div_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [DIV_W-1:0] w_div_next;
  logic             w_div_wrap;
  logic             w_bit_wrap;

  assign w_div_wrap = (r_div_cnt == DIV_W'(SCK_DIV - 1));
  assign w_div_next = w_div_wrap ? '0 : r_div_cnt + 1'b1;
  assign w_bit_wrap = w_div_wrap && (r_bit_cnt == BIT_W'(FRAME_BITS - 1));

  // sck is computed from the next divider value so it stays aligned with div_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      sck         <= 1'b0;
      ws          <= 1'b0;
      frame_start <= 1'b0;
      half_frame  <= 1'b0;
    end else begin
      r_div_cnt   <= w_div_next;
      sck         <= (w_div_next >= DIV_W'(SCK_DIV / 2));
      if (w_div_wrap) begin
        r_bit_cnt <= (r_bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : r_bit_cnt + 1'b1;
      end
      if (w_bit_wrap) begin
        ws <= ~ws;
      end
      frame_start <= w_bit_wrap && (ws != WS_LEFT);
      half_frame  <= w_bit_wrap && (ws == WS_LEFT);
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_tx_scheduler.sv
// ============================================================================
// i2s_tx_scheduler : arbitrates two stereo AXI-Stream sources into one L/R pair
// per I2S frame. Rev 1.0
// ============================================================================
`default_nettype none

module i2s_tx_scheduler
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SCK_DIV    = DEF_SCK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic                  s0_tlast,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic                  s1_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic                  src_sel,
  input  logic                  mute,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  sck,
  output logic                  ws,
  output logic                  active_src,
  output logic [CNT_W-1:0]      underrun_cnt,
  output logic [CNT_W-1:0]      resync_cnt
);

  logic                  w_frame_start;
  logic                  w_half_frame;
  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_left, r_right, w_left_next, w_right_next;
  logic                  w_active_next;
  logic                  w_under_inc, w_resync_inc;
  logic                  w_get, w_tvalid, w_tlast, w_accept;
  logic [DATA_WIDTH-1:0] w_tdata;

  i2s_clk_gen #(
    .SCK_DIV    (SCK_DIV),
    .FRAME_BITS (FRAME_BITS)
  ) u_clk_gen (
    .clk         (S_AXIS_ACLK),
    .rst_n       (S_AXIS_ARESETN),
    .sck         (sck),
    .ws          (ws),
    .frame_start (w_frame_start),
    .half_frame  (w_half_frame)
  );

  assign w_get     = (r_state == ST_GET_L) || (r_state == ST_GET_R);
  assign s0_tready = w_get && !active_src;
  assign s1_tready = w_get && active_src;
  assign w_tvalid  = active_src ? s1_tvalid : s0_tvalid;
  assign w_tlast   = active_src ? s1_tlast  : s0_tlast;
  assign w_tdata   = active_src ? s1_tdata  : s0_tdata;
  assign w_accept  = w_get && w_tvalid;

  assign M_AXIS_TVALID = (r_state == ST_PUT_L) || (r_state == ST_PUT_R);
  assign M_AXIS_TLAST  = (r_state == ST_PUT_R);
  assign M_AXIS_TDATA  = (!M_AXIS_TVALID || mute) ? '0 :
                         (r_state == ST_PUT_R) ? r_right : r_left;

  always_comb begin
    w_state_next  = r_state;
    w_left_next   = r_left;
    w_right_next  = r_right;
    w_active_next = active_src;
    w_under_inc   = 1'b0;
    w_resync_inc  = 1'b0;
    case (r_state)
      ST_IDLE, ST_HOLD: begin
        if (w_frame_start) begin
          w_state_next  = ST_GET_L;
          w_active_next = src_sel;
        end
      end
      ST_GET_L, ST_GET_R: begin
        // The deadline wins over a word accepted in the same cycle
        if (w_half_frame) begin
          w_left_next  = '0;
          w_right_next = '0;
          w_under_inc  = 1'b1;
          w_state_next = ST_PUT_L;
        end else if (w_accept) begin
          if (r_state == ST_GET_L) begin
            if (w_tlast == TLAST_RIGHT) begin
              w_resync_inc = 1'b1;
            end else begin
              w_left_next  = w_tdata;
              w_state_next = ST_GET_R;
            end
          end else begin
            if (w_tlast == TLAST_RIGHT) begin
              w_right_next = w_tdata;
              w_state_next = ST_PUT_L;
            end else begin
              w_left_next  = w_tdata;
              w_resync_inc = 1'b1;
            end
          end
        end
      end
      ST_PUT_L: begin
        w_under_inc = w_frame_start;
        if (M_AXIS_TREADY) w_state_next = ST_PUT_R;
      end
      ST_PUT_R: begin
        w_under_inc = w_frame_start;
        if (M_AXIS_TREADY) w_state_next = ST_HOLD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_state      <= ST_IDLE;
      r_left       <= '0;
      r_right      <= '0;
      active_src   <= 1'b0;
      underrun_cnt <= '0;
      resync_cnt   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_left     <= w_left_next;
      r_right    <= w_right_next;
      active_src <= w_active_next;
      if (w_under_inc && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + 1'b1;
      if (w_resync_inc && (resync_cnt != '1)) resync_cnt <= resync_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_scheduler.sv
// Directed bench for i2s_tx_scheduler: timing, arbitration, underrun, resync, mute, reset.
`default_nettype none

module tb_i2s_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s0_tdata, s1_tdata;
  logic        s0_tlast, s0_tvalid, s0_tready;
  logic        s1_tlast, s1_tvalid, s1_tready;
  logic        src_sel, mute;
  logic [31:0] m_tdata;
  logic        m_tlast, m_tvalid, m_tready;
  logic        sck, ws, active_src;
  logic [7:0]  underrun_cnt, resync_cnt;

  int checks = 0;
  int errors = 0;

  i2s_tx_scheduler dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .s0_tdata       (s0_tdata),
    .s0_tlast       (s0_tlast),
    .s0_tvalid      (s0_tvalid),
    .s0_tready      (s0_tready),
    .s1_tdata       (s1_tdata),
    .s1_tlast       (s1_tlast),
    .s1_tvalid      (s1_tvalid),
    .s1_tready      (s1_tready),
    .src_sel        (src_sel),
    .mute           (mute),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TREADY  (m_tready),
    .sck            (sck),
    .ws             (ws),
    .active_src     (active_src),
    .underrun_cnt   (underrun_cnt),
    .resync_cnt     (resync_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  task automatic send(input logic src, input logic [31:0] data, input logic last);
    int  n;
    logic rdy;
    if (src) begin
      s1_tdata = data; s1_tlast = last; s1_tvalid = 1'b1;
    end else begin
      s0_tdata = data; s0_tlast = last; s0_tvalid = 1'b1;
    end
    n = 0;
    rdy = src ? s1_tready : s0_tready;
    while (!rdy && n < 3000) begin
      step(1);
      n++;
      rdy = src ? s1_tready : s0_tready;
    end
    if (!rdy) timeout("send_wait");
    else step(1);
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
  endtask

  task automatic wait_mvalid(input string tag);
    int n;
    n = 0;
    while (!m_tvalid && n < 3000) begin
      step(1);
      n++;
    end
    if (!m_tvalid) timeout(tag);
  endtask

  task automatic wait_ws(input logic val, input string tag);
    int n;
    n = 0;
    while (ws !== val && n < 1000) begin
      step(1);
      n++;
    end
    if (ws !== val) timeout(tag);
  endtask

  task automatic expect_m(input string tag, input logic [31:0] data, input logic last);
    wait_mvalid({tag, "_wait"});
    check({tag, "_data"}, m_tdata, data);
    check({tag, "_last"}, {31'b0, m_tlast}, {31'b0, last});
    step(1);
  endtask

  initial begin
    rst_n = 1'b0;
    s0_tdata = '0; s0_tlast = 1'b0; s0_tvalid = 1'b0;
    s1_tdata = '0; s1_tlast = 1'b0; s1_tvalid = 1'b0;
    src_sel = 1'b0; mute = 1'b0; m_tready = 1'b1;
    step(3);
    check("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("rst_sck", {31'b0, sck}, 32'd0);
    rst_n = 1'b1;

    // Timing: sck period 8, ws toggles every 256, first frame_start after edge 512
    step(3);   check("sck_k3", {31'b0, sck}, 32'd0);
    step(1);   check("sck_k4", {31'b0, sck}, 32'd1);
    step(4);   check("sck_k8", {31'b0, sck}, 32'd0);
    step(4);   check("sck_k12", {31'b0, sck}, 32'd1);
    step(243); check("ws_k255", {31'b0, ws}, 32'd0);
    step(1);   check("ws_k256", {31'b0, ws}, 32'd1);
    step(255);
    check("ws_k511", {31'b0, ws}, 32'd1);
    check("idle_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("idle_s0_tready", {31'b0, s0_tready}, 32'd0);
    check("idle_tdata", m_tdata, 32'd0);
    check("idle_underrun", {24'b0, underrun_cnt}, 32'd0);
    check("idle_resync", {24'b0, resync_cnt}, 32'd0);
    step(1);
    check("ws_k512", {31'b0, ws}, 32'd0);
    check("s0_tready_k512", {31'b0, s0_tready}, 32'd0);
    step(1);
    check("s0_tready_k513", {31'b0, s0_tready}, 32'd1);

    // Basic pair from s0
    send(1'b0, 32'h11111111, 1'b0);
    check("getr_s0_tready", {31'b0, s0_tready}, 32'd1);
    check("getr_s1_tready", {31'b0, s1_tready}, 32'd0);
    send(1'b0, 32'h22222222, 1'b1);
    expect_m("p1_l", 32'h11111111, 1'b0);
    expect_m("p1_r", 32'h22222222, 1'b1);
    check("p1_active", {31'b0, active_src}, 32'd0);
    check("hold_tvalid", {31'b0, m_tvalid}, 32'd0);

    // Source switch mid-frame only takes effect at the next frame_start
    send(1'b0, 32'h33333333, 1'b0);
    src_sel = 1'b1;
    send(1'b0, 32'h44444444, 1'b1);
    check("sw_active_old", {31'b0, active_src}, 32'd0);
    expect_m("p2_l", 32'h33333333, 1'b0);
    expect_m("p2_r", 32'h44444444, 1'b1);
    send(1'b1, 32'hAAAA5555, 1'b0);
    check("sw_active_new", {31'b0, active_src}, 32'd1);
    check("sw_s0_tready", {31'b0, s0_tready}, 32'd0);
    send(1'b1, 32'h5555AAAA, 1'b1);
    expect_m("p3_l", 32'hAAAA5555, 1'b0);
    expect_m("p3_r", 32'h5555AAAA, 1'b1);

    // Underrun at half_frame, then a frame_start while stalled in PUT_L
    src_sel = 1'b0;
    m_tready = 1'b0;
    wait_mvalid("ur_wait");
    check("ur_tdata", m_tdata, 32'd0);
    check("ur_tlast", {31'b0, m_tlast}, 32'd0);
    check("ur_cnt1", {24'b0, underrun_cnt}, 32'd1);
    wait_ws(1'b0, "ur_ws_wait");
    step(2);
    check("ur_cnt2", {24'b0, underrun_cnt}, 32'd2);
    check("ur_tvalid_held", {31'b0, m_tvalid}, 32'd1);
    check("ur_tlast_held", {31'b0, m_tlast}, 32'd0);
    m_tready = 1'b1;
    expect_m("ur_l", 32'd0, 1'b0);
    expect_m("ur_r", 32'd0, 1'b1);

    // Stray right word dropped, then pair forwarded in order
    send(1'b0, 32'hDEADBEEF, 1'b1);
    check("rs_cnt1", {24'b0, resync_cnt}, 32'd1);
    send(1'b0, 32'h12345678, 1'b0);
    send(1'b0, 32'h9ABCDEF0, 1'b1);
    expect_m("rs_l", 32'h12345678, 1'b0);
    expect_m("rs_r", 32'h9ABCDEF0, 1'b1);
    for (int i = 0; i < 300; i++) send(1'b0, 32'h0BAD0000 + 32'(i), 1'b1);
    check("rs_sat", {24'b0, resync_cnt}, 32'd255);
    wait_ws(1'b1, "drain_ws_wait");
    step(4);

    // Mute zeroes data but keeps handshakes
    mute = 1'b1;
    send(1'b0, 32'hCAFEF00D, 1'b0);
    send(1'b0, 32'h0BADF00D, 1'b1);
    expect_m("mute_l", 32'd0, 1'b0);
    expect_m("mute_r", 32'd0, 1'b1);
    check("mute_hold_tvalid", {31'b0, m_tvalid}, 32'd0);

    // Asynchronous reset while in PUT_L
    mute = 1'b0;
    m_tready = 1'b0;
    send(1'b0, 32'h5A5A5A5A, 1'b0);
    send(1'b0, 32'hA5A5A5A5, 1'b1);
    wait_mvalid("ar_wait");
    check("ar_tdata_pre", m_tdata, 32'h5A5A5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_tvalid", {31'b0, m_tvalid}, 32'd0);
    check("ar_tdata", m_tdata, 32'd0);
    check("ar_underrun", {24'b0, underrun_cnt}, 32'd0);
    check("ar_resync", {24'b0, resync_cnt}, 32'd0);
    check("ar_active", {31'b0, active_src}, 32'd0);
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
